// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 responder: FSM states, bus transfer record,
// DDRAM geometry, instruction masks, error bit positions and address helpers.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_FILL,
        ST_BUSY
    } state_t;

    typedef enum logic {
        MODE_DDRAM,
        MODE_CGRAM
    } mode_t;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } bus_xfer_t;

    localparam logic [7:0] CG_SPACE       = 8'h20;
    localparam logic [6:0] LINE1_BASE     = 7'h00;
    localparam logic [6:0] LINE2_BASE     = 7'h40;
    localparam logic [6:0] LINE1_LAST     = 7'h27;
    localparam logic [6:0] LINE2_LAST     = 7'h67;
    localparam int         LINE_LEN       = 40;
    localparam int         DDRAM_DEPTH    = 80;
    localparam logic [6:0] DDRAM_LAST_IDX = 7'(DDRAM_DEPTH - 1);
    localparam logic [6:0] LINE1_DONE     = 7'h0F;
    localparam logic [6:0] LINE2_DONE     = 7'h4F;

    // Instruction masks; the highest set bit selects the instruction.
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam int ERR_BUSY  = 0;
    localparam int ERR_RW    = 1;
    localparam int ERR_FUNC  = 2;
    localparam int ERR_UNSUP = 3;

    // Address counter step with the two-line wrap of the controller.
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (a == LINE1_LAST) return LINE2_BASE;
        if (a == LINE2_LAST) return LINE1_BASE;
        return a + 7'd1;
    endfunction

    function automatic logic [6:0] addr_dec(input logic [6:0] a);
        if (a == LINE1_BASE) return LINE2_LAST;
        if (a == LINE2_BASE) return LINE1_LAST;
        return a - 7'd1;
    endfunction

    // Map an arbitrary Set-DDRAM value onto the populated address ranges.
    function automatic logic [6:0] addr_legalise(input logic [6:0] a);
        if (a > LINE1_LAST && a < LINE2_BASE) return LINE2_BASE;
        if (a > LINE2_LAST) return LINE1_BASE;
        return a;
    endfunction

    // Linear mirror index: line 1 at 0..39, line 2 at 40..79.
    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        if (a < LINE2_BASE) return a;
        return a - LINE2_BASE + 7'(LINE_LEN);
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one synchronous write port, one registered read port.
// Indices beyond the array read back as a space character.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [DDRAM_DEPTH];

    // Write port; contents are initialised by the clear fill rather than by reset.
    // NOTE: the storage array is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (we && waddr <= DDRAM_LAST_IDX) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write to the same index returns the old byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 8'h00;
        end else if (raddr <= DDRAM_LAST_IDX) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= CG_SPACE;
        end
    end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// Responder end of an 8-bit HD44780 bus. Synchronises the asynchronous bus,
// decodes each transfer on the falling edge of E and keeps a DDRAM mirror.
module lcd_hd44780_rx
    import lcd_pkg::*;
#(
    parameter int CMD_CYCLES  = 3700,
    parameter int CLR_CYCLES  = 153000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] ddram_addr,
    output logic       disp_on,
    output logic [1:0] line_done,
    output logic [3:0] err
);

    localparam int TIMER_MAX = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] CMD_LOAD  = TIMER_W'(CMD_CYCLES);
    localparam logic [TIMER_W-1:0] CLR_LOAD  = TIMER_W'(CLR_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    logic [SYNC_STAGES-1:0] e_sync;
    logic                   e_prev;
    bus_xfer_t              bus_sync [SYNC_STAGES];
    logic                   strobe;
    bus_xfer_t              xfer_q;
    logic                   drop_q;
    logic [7:0]             cmd;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [6:0]           fill_q, fill_d;
    logic [6:0]           addr_q, addr_d;
    logic                 id_q, id_d;
    mode_t                mode_q, mode_d;
    logic                 disp_q, disp_d;
    logic [3:0]           err_q, err_d;

    logic                 mem_we;
    logic [6:0]           mem_waddr;
    logic [7:0]           mem_wdata;

    // Multi-flop synchroniser on every bus pin plus a delayed copy of E for edge detect.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_sync <= '0;
            e_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                bus_sync[i] <= '0;
            end
        end else begin
            e_sync      <= {e_sync[SYNC_STAGES-2:0], lcd_e};
            e_prev      <= e_sync[SYNC_STAGES-1];
            bus_sync[0] <= {lcd_rs, lcd_rw, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bus_sync[i] <= bus_sync[i-1];
            end
        end
    end

    assign strobe = e_prev & ~e_sync[SYNC_STAGES-1];
    assign cmd    = xfer_q.data;

    // Latch the transfer on the strobe and note whether it arrived while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_q <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= strobe && (state_q != ST_IDLE);
            if (strobe) begin
                xfer_q <= bus_sync[SYNC_STAGES-1];
            end
        end
    end

    // Controller state; reset behaves like a Clear Display instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
            timer_q <= CLR_LOAD;
            fill_q  <= '0;
            addr_q  <= LINE1_BASE;
            id_q    <= 1'b1;
            mode_q  <= MODE_DDRAM;
            disp_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            mode_q  <= mode_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
        end
    end

    // Instruction decode, clear fill sequencing and busy timing.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q != '0) ? timer_q - TIMER_ONE : '0;
        fill_d    = fill_q;
        addr_d    = addr_q;
        id_d      = id_q;
        mode_d    = mode_q;
        disp_d    = disp_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = fill_q;
        mem_wdata = CG_SPACE;
        line_done = 2'b00;

        if (drop_q) begin
            err_d[ERR_BUSY] = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_BUSY;
                timer_d = CMD_LOAD;
                if (xfer_q.rw) begin
                    err_d[ERR_RW] = 1'b1;
                    state_d       = ST_IDLE;
                    timer_d       = '0;
                end else if (xfer_q.rs) begin
                    // CGRAM-mode data is accepted on the bus but not mirrored.
                    if (mode_q == MODE_DDRAM) begin
                        mem_we       = 1'b1;
                        mem_waddr    = ddram_index(addr_q);
                        mem_wdata    = cmd;
                        line_done[0] = (addr_q == LINE1_DONE);
                        line_done[1] = (addr_q == LINE2_DONE);
                        addr_d       = id_q ? addr_inc(addr_q) : addr_dec(addr_q);
                    end
                end else if (|(cmd & OP_DDRAM)) begin
                    mode_d = MODE_DDRAM;
                    addr_d = addr_legalise(cmd[6:0]);
                end else if (|(cmd & OP_CGRAM)) begin
                    mode_d = MODE_CGRAM;
                end else if (|(cmd & OP_FUNC)) begin
                    // Bus width and line count are fixed; other settings are flagged only.
                    if (!cmd[4] || !cmd[3]) begin
                        err_d[ERR_FUNC] = 1'b1;
                    end
                end else if (|(cmd & OP_SHIFT)) begin
                    if (cmd[3]) begin
                        err_d[ERR_UNSUP] = 1'b1;
                    end else begin
                        addr_d = cmd[2] ? addr_inc(addr_q) : addr_dec(addr_q);
                    end
                end else if (|(cmd & OP_DISP)) begin
                    // Cursor and blink have no visible effect on the mirror.
                    disp_d = cmd[2];
                end else if (|(cmd & OP_ENTRY)) begin
                    id_d = cmd[1];
                    if (cmd[0]) begin
                        err_d[ERR_UNSUP] = 1'b1;
                    end
                end else if (|(cmd & OP_HOME)) begin
                    addr_d  = LINE1_BASE;
                    timer_d = CLR_LOAD;
                end else if (|(cmd & OP_CLEAR)) begin
                    fill_d  = '0;
                    addr_d  = LINE1_BASE;
                    id_d    = 1'b1;
                    mode_d  = MODE_DDRAM;
                    timer_d = CLR_LOAD;
                    state_d = ST_FILL;
                end else begin
                    err_d[ERR_UNSUP] = 1'b1;
                end
            end
            ST_FILL: begin
                mem_we = 1'b1;
                fill_d = fill_q + 7'd1;
                if (fill_q == DDRAM_LAST_IDX) begin
                    fill_d  = '0;
                    state_d = (timer_q <= TIMER_ONE) ? ST_IDLE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (timer_q <= TIMER_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    lcd_ddram u_ddram (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign busy       = (state_q == ST_FILL) || (state_q == ST_BUSY);
    assign ddram_addr = addr_q;
    assign disp_on    = disp_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Self-checking bench for lcd_hd44780_rx: a transfer-level model of the display
// (line/column cursor, byte image, busy deadline) compared against the DUT every cycle.
module tb_lcd_hd44780_rx;

    localparam int CMD  = 8;
    localparam int CLR  = 100;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic [6:0] ddram_addr;
    logic       disp_on;
    logic [1:0] line_done;
    logic [3:0] err;

    lcd_hd44780_rx #(
        .CMD_CYCLES  (CMD),
        .CLR_CYCLES  (CLR),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .ddram_addr (ddram_addr),
        .disp_on    (disp_on),
        .line_done  (line_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_end = 0;
    int ld1_count = 0;
    bit checking = 1'b0;

    // Model state: cursor as line/column, display image, flags.
    logic [7:0] mem_m [80];
    int         line_m, col_m;
    bit         id_m, cg_m, disp_m;
    logic [3:0] err_m;
    logic [1:0] ld_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int addr_m();
        return line_m * 'h40 + col_m;
    endfunction

    task automatic step(input bit up);
        if (up) begin
            col_m++;
            if (col_m == 40) begin col_m = 0; line_m ^= 1; end
        end else if (col_m == 0) begin
            col_m = 39; line_m ^= 1;
        end else begin
            col_m--;
        end
    endtask

    task automatic set_ddram(input int a);
        if (a < 'h40) begin
            if (a < 40) begin line_m = 0; col_m = a; end
            else begin line_m = 1; col_m = 0; end
        end else if (a - 'h40 < 40) begin
            line_m = 1; col_m = a - 'h40;
        end else begin
            line_m = 0; col_m = 0;
        end
    endtask

    task automatic model_reset();
        line_m = 0; col_m = 0; id_m = 1; cg_m = 0; disp_m = 0;
        err_m = '0; ld_m = '0;
        for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
        busy_end = cyc + CLR;
    endtask

    task automatic apply(input bit drop, input bit rs, input bit rw, input logic [7:0] d);
        if (drop) err_m[0] = 1'b1;
        else if (rw) err_m[1] = 1'b1;
        else begin
            busy_end = cyc + CMD;
            if (rs) begin
                if (!cg_m) begin
                    mem_m[line_m * 40 + col_m] = d;
                    step(id_m);
                end
            end
            else if (d >= 8'h80) begin cg_m = 0; set_ddram(int'(d) - 'h80); end
            else if (d >= 8'h40) cg_m = 1;
            else if (d >= 8'h20) begin if (!d[4] || !d[3]) err_m[2] = 1'b1; end
            else if (d >= 8'h10) begin if (d[3]) err_m[3] = 1'b1; else step(d[2]); end
            else if (d >= 8'h08) disp_m = d[2];
            else if (d >= 8'h04) begin id_m = d[1]; if (d[0]) err_m[3] = 1'b1; end
            else if (d >= 8'h02) begin line_m = 0; col_m = 0; busy_end = cyc + CLR; end
            else if (d == 8'h01) begin
                for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
                line_m = 0; col_m = 0; id_m = 1; cg_m = 0;
                busy_end = cyc + CLR;
            end
        end
    endtask

    // Every-cycle comparison of the DUT's status outputs with the model.
    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, cyc < busy_end);
            check("ddram_addr", ddram_addr, addr_m());
            check("disp_on", disp_on, disp_m);
            check("err", err, err_m);
            check("line_done", line_done, ld_m);
            if (line_done[1] === 1'b1) ld1_count++;
        end
    end

    // One bus transfer with an E-high pulse of hi cycles; the model follows the
    // transfer timing: strobe seen SYNC clocks after the fall, effect SYNC+2 clocks after.
    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int hi);
        bit drop;
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1 drop = (cyc < busy_end);
        @(posedge clk);
        #1 if (!drop && !rw && rs && !cg_m && col_m == 15) ld_m[line_m] = 1'b1;
        @(posedge clk);
        #1 ld_m = '0;
        apply(drop, rs, rw, d);
    endtask

    task automatic cmd(input logic [7:0] d);
        xfer(1'b0, 1'b0, d, 20);
    endtask

    task automatic dat(input logic [7:0] d);
        xfer(1'b1, 1'b0, d, 20);
    endtask

    task automatic wait_idle();
        while (cyc < busy_end) @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string name, input int idx, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = 7'(idx);
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    task automatic check_all_mem();
        for (int i = 0; i < 80; i++) check_mem("mem_image", i, mem_m[i]);
    endtask

    task automatic count_busy(input string name, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(posedge clk);
            #1;
        end
        check(name, n, exp);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        checking = 1'b0;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        reset = 1'b1; lcd_e = 0; lcd_rs = 0; lcd_rw = 0; lcd_data = 8'h00; rd_addr = 7'd0;

        // Reset state and power-on clear.
        do_reset(3);
        check("rst_busy", busy, 1);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_err", err, 4'h0);
        check("rst_addr", ddram_addr, 7'h00);
        check("rst_line_done", line_done, 2'b00);
        checking = 1'b1;
        count_busy("rst_busy_len", 100);
        check_mem("rst_mem0", 0, 8'h20);
        check_mem("rst_mem39", 39, 8'h20);
        check_mem("rst_mem79", 79, 8'h20);
        check_mem("rd_out_of_range", 100, 8'h20);

        // Initialisation and a date string on line 1.
        cmd(8'h38); cmd(8'h06); cmd(8'h0C); cmd(8'h80);
        s = "2024/01/01";
        for (int i = 0; i < s.len(); i++) dat(s[i]);
        check("date_addr", ddram_addr, 7'h0A);
        check("date_disp_on", disp_on, 1);
        check_mem("date_mem0", 0, 8'h32);
        check_mem("date_mem4", 4, 8'h2F);
        check_mem("date_mem9", 9, 8'h31);

        // Line 2, sixteen bytes; line_done[1] on the sixteenth.
        ld1_count = 0;
        cmd(8'hC0);
        for (int i = 0; i < 16; i++) dat(8'h61 + 8'(i));
        check("line2_addr", ddram_addr, 7'h50);
        check("line2_done_pulses", ld1_count, 1);
        check_mem("line2_mem55", 55, 8'h70);

        // Wrap across the line boundary both ways.
        cmd(8'hA7); dat(8'h41); dat(8'h42);
        check("wrap_inc_addr", ddram_addr, 7'h41);
        check_mem("wrap_mem39", 39, 8'h41);
        check_mem("wrap_mem40", 40, 8'h42);
        cmd(8'h04); cmd(8'hC0); dat(8'h43); dat(8'h44);
        check("wrap_dec_addr", ddram_addr, 7'h26);
        check_mem("wrap_dec_mem40", 40, 8'h43);
        check_mem("wrap_dec_mem39", 39, 8'h44);

        // A strobe landing while busy is dropped.
        dat(8'h5A);
        xfer(1'b1, 1'b0, 8'h77, 2);
        wait_idle();
        check("drop_err0", err[0], 1);
        check_mem("drop_mem38", 38, 8'h5A);
        check_mem("drop_mem37", 37, 8'h20);
        check_all_mem();

        // Cursor shift with wrap, and an unsupported display shift.
        cmd(8'h06); cmd(8'h80); cmd(8'h10);
        check("shift_left_wrap", ddram_addr, 7'h67);
        cmd(8'h14);
        check("shift_right_wrap", ddram_addr, 7'h00);
        cmd(8'h1C);
        check("shift_sc_err3", err[3], 1);

        // Clear Display after both lines were written.
        cmd(8'h01);
        count_busy("clr_busy_len", 100);
        check("clr_addr", ddram_addr, 7'h00);
        check_all_mem();

        // Function set with N=0, then a read cycle.
        cmd(8'h30);
        check("func_err2", err[2], 1);
        xfer(1'b0, 1'b1, 8'h80, 20);
        check("rw_err1", err[1], 1);
        check("err_all_sticky", err, 4'hF);

        // Reset in the middle of a clear fill restarts the fill and the timer.
        cmd(8'h01);
        repeat (20) @(posedge clk);
        do_reset(2);
        checking = 1'b1;
        check("rst2_err", err, 4'h0);
        count_busy("rst2_busy_len", 100);
        check_all_mem();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
